// File: rtl/uart2axis_pkg.sv
// Shared types and sizing helpers for the uart2axis receiver.
package uart2axis_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   localparam int unsigned DEF_CLKS_PER_BIT = 868;
   localparam int unsigned DEF_TIMEOUT_BITS = 20;

   // Bit counter width: holds clks_per_bit-1.
   function automatic int unsigned bcnt_width(input int unsigned clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

   // Idle timeout counter width: holds timeout_bits-1.
   function automatic int unsigned tcnt_width(input int unsigned timeout_bits);
      return $clog2(timeout_bits + 1);
   endfunction

   localparam int unsigned BCNT_W = bcnt_width(DEF_CLKS_PER_BIT);
   localparam int unsigned TCNT_W = tcnt_width(DEF_TIMEOUT_BITS);

endpackage

// File: rtl/uart2axis_fifo.sv
// Synchronous show-ahead FIFO; a push while full is taken only alongside a pop.
module uart2axis_fifo
   import uart2axis_pkg::*;
#(
   parameter int unsigned width = 9,
   parameter int unsigned depth = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [width-1:0] i_data,
   input  logic             i_pop,
   output logic [width-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(depth);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [width-1:0] mem_q [depth];
   logic [width-1:0] mem_d [depth];
   logic             do_push;
   logic             do_pop;

   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance and storage write for the accepted push/pop.
   always_comb begin
      do_pop   = i_pop && !o_empty;
      do_push  = i_push && (!o_full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = i_data;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // FIFO state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/uart2axis.sv
// 8N1 UART receiver feeding an AXI-Stream byte master with EOL/timeout packetisation.
module uart2axis
   import uart2axis_pkg::*;
#(
   parameter int unsigned clks_per_bit = 868,
   parameter int unsigned fifo_depth   = 4,
   parameter logic [7:0]  eol_char     = 8'h0a,
   parameter int unsigned timeout_bits = 20
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_frame_err,
   output logic       o_overflow
);

   localparam int unsigned BW = bcnt_width(clks_per_bit);
   localparam int unsigned TW = tcnt_width(timeout_bits);
   localparam logic [BW-1:0] BIT_RELOAD  = BW'(clks_per_bit - 1);
   localparam logic [BW-1:0] HALF_RELOAD = BW'(clks_per_bit / 2 - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(timeout_bits - 1);

   logic          rx_meta_q, rx_q;
   state_e        state_q, state_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          pend_v_q, pend_v_d;
   logic [7:0]    pend_b_q, pend_b_d;
   logic          eol_push_q, eol_push_d;
   logic          frame_err_q, frame_err_d;
   logic          ovf_q, ovf_d;

   logic          expired;
   logic          push;
   logic [8:0]    push_data;
   logic [8:0]    fifo_data;
   logic          fifo_full;
   logic          fifo_empty;

   assign expired     = (bcnt_q == '0);
   assign o_tvalid    = !fifo_empty;
   assign o_tdata     = fifo_data[7:0];
   assign o_tlast     = fifo_data[8];
   assign o_frame_err = frame_err_q;
   assign o_overflow  = ovf_q;

   // Two-flop synchroniser for the asynchronous serial line, idle-high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta_q <= 1'b1;
         rx_q      <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_q      <= rx_meta_q;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= WAIT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_IDLE: if (rx_q && expired) state_d = IDLE;
         IDLE:      if (!rx_q) state_d = START;
         START:     if (expired) state_d = rx_q ? IDLE : DATA;
         DATA:      if (expired && (bidx_q == 3'd7)) state_d = STOP;
         STOP:      if (expired) state_d = rx_q ? IDLE : WAIT_IDLE;
         default:   state_d = WAIT_IDLE;
      endcase
   end

   // FSM outputs: bit timing, shifting, pending register, timeout and FIFO pushes.
   always_comb begin
      bcnt_d      = bcnt_q;
      bidx_d      = bidx_q;
      shreg_d     = shreg_q;
      tcnt_d      = tcnt_q;
      pend_v_d    = pend_v_q;
      pend_b_d    = pend_b_q;
      eol_push_d  = 1'b0;
      frame_err_d = 1'b0;
      push        = 1'b0;
      push_data   = '0;

      // Second half of a pending+EOL pair, one cycle after the first push.
      if (eol_push_q) begin
         push      = 1'b1;
         push_data = {1'b1, eol_char};
      end

      unique case (state_q)
         WAIT_IDLE: begin
            // The synchroniser resets high, so a line held low through reset
            // looks idle for two cycles; a full high bit period is demanded
            // before arming start detection.
            if (!rx_q || expired) bcnt_d = BIT_RELOAD;
            else                  bcnt_d = bcnt_q - BW'(1);
         end
         IDLE: begin
            if (!rx_q) begin
               bcnt_d = HALF_RELOAD;
               tcnt_d = '0;
            end else if (expired) begin
               bcnt_d = BIT_RELOAD;
               if (pend_v_q) begin
                  if (tcnt_q == TMO_LAST) begin
                     push      = 1'b1;
                     push_data = {1'b1, pend_b_q};
                     pend_v_d  = 1'b0;
                     tcnt_d    = '0;
                  end else begin
                     tcnt_d = tcnt_q + TW'(1);
                  end
               end
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         START: begin
            if (expired) begin
               bcnt_d = BIT_RELOAD;
               bidx_d = '0;
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         DATA: begin
            if (expired) begin
               shreg_d = {rx_q, shreg_q[7:1]};
               bcnt_d  = BIT_RELOAD;
               bidx_d  = bidx_q + 3'd1;
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         STOP: begin
            if (expired) begin
               bcnt_d = BIT_RELOAD;
               if (!rx_q) begin
                  frame_err_d = 1'b1;
               end else if (shreg_q == eol_char) begin
                  push     = 1'b1;
                  pend_v_d = 1'b0;
                  if (pend_v_q) begin
                     push_data  = {1'b0, pend_b_q};
                     eol_push_d = 1'b1;
                  end else begin
                     push_data = {1'b1, eol_char};
                  end
               end else begin
                  if (pend_v_q) begin
                     push      = 1'b1;
                     push_data = {1'b0, pend_b_q};
                  end
                  pend_v_d = 1'b1;
                  pend_b_d = shreg_q;
               end
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         default: bcnt_d = BIT_RELOAD;
      endcase

      ovf_d = push && fifo_full && !i_tready;
   end

   // Datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bcnt_q      <= BIT_RELOAD;
         bidx_q      <= '0;
         shreg_q     <= '0;
         tcnt_q      <= '0;
         pend_v_q    <= 1'b0;
         pend_b_q    <= '0;
         eol_push_q  <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         bcnt_q      <= bcnt_d;
         bidx_q      <= bidx_d;
         shreg_q     <= shreg_d;
         tcnt_q      <= tcnt_d;
         pend_v_q    <= pend_v_d;
         pend_b_q    <= pend_b_d;
         eol_push_q  <= eol_push_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= ovf_d;
      end
   end

   uart2axis_fifo #(
      .width (9),
      .depth (fifo_depth)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (push_data),
      .i_pop   (i_tready),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

endmodule

// File: tb/tb_uart2axis.sv
// Directed and randomized bench for uart2axis against a byte-level packet model.
module tb_uart2axis;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 20;
   localparam logic [7:0]  EOL   = 8'h0a;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       tready;
   logic [7:0] tdata;
   logic       tlast;
   logic       tvalid;
   logic       ferr;
   logic       ovf;

   uart2axis #(
      .clks_per_bit (CPB),
      .fifo_depth   (DEPTH),
      .eol_char     (EOL),
      .timeout_bits (TMO)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_uart_rx   (rx),
      .o_tdata     (tdata),
      .o_tlast     (tlast),
      .o_tvalid    (tvalid),
      .i_tready    (tready),
      .o_frame_err (ferr),
      .o_overflow  (ovf)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [8:0]  exp_q [$];
   logic [8:0]  got_q [$];
   int unsigned got_cyc [$];
   int unsigned ferr_cnt = 0;
   int unsigned ovf_cnt  = 0;
   int unsigned exp_ferr = 0;
   int unsigned exp_ovf  = 0;
   int unsigned last_stop_cyc = 0;

   // Reference model state: one held byte, and FIFO occupancy while stalled.
   bit          mdl_pv = 1'b0;
   logic [7:0]  mdl_pb = '0;
   bit          stall = 1'b0;
   int unsigned stall_occ = 0;
   bit          rand_ready = 1'b0;

   bit          prev_stall = 1'b0;
   logic [8:0]  prev_beat = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_push(input logic [8:0] e);
      if (stall && stall_occ == DEPTH) begin
         exp_ovf++;
      end else begin
         exp_q.push_back(e);
         if (stall) stall_occ++;
      end
   endtask

   task automatic mdl_byte(input logic [7:0] b);
      if (b == EOL) begin
         if (mdl_pv) mdl_push({1'b0, mdl_pb});
         mdl_push({1'b1, b});
         mdl_pv = 1'b0;
      end else begin
         if (mdl_pv) mdl_push({1'b0, mdl_pb});
         mdl_pv = 1'b1;
         mdl_pb = b;
      end
   endtask

   task automatic mdl_timeout();
      if (mdl_pv) mdl_push({1'b1, mdl_pb});
      mdl_pv = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      @(posedge clk); #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk);
         #1 rx = b[i];
      end
      repeat (CPB) @(posedge clk);
      #1 rx = stop_bit;
      last_stop_cyc = cyc;
      repeat (CPB) @(posedge clk);
      #1 rx = 1'b1;
   endtask

   task automatic wait_beats(input int unsigned n, input int unsigned budget);
      int unsigned k = 0;
      while (got_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
   endtask

   task automatic check_stream(input string tag);
      wait_beats(exp_q.size(), 3000);
      repeat (30) @(posedge clk);
      chk({tag, "_beats"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
      end
      chk({tag, "_frame_err"}, ferr_cnt, exp_ferr);
      chk({tag, "_overflow"}, ovf_cnt, exp_ovf);
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   // Stream monitor: collects handshakes, counts pulses, checks stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            vectors++;
            assert (tvalid === 1'b1 && {tlast, tdata} === prev_beat) else begin
               miscompares++;
               $error("FAIL axis_stable: got valid=%0b beat=%03h expected valid=1 beat=%03h",
                      tvalid, {tlast, tdata}, prev_beat);
            end
         end
         if (tvalid === 1'b1 && tready === 1'b1) begin
            got_q.push_back({tlast, tdata});
            got_cyc.push_back(cyc);
         end
         if (ferr === 1'b1) ferr_cnt++;
         if (ovf === 1'b1) ovf_cnt++;
         prev_stall = (tvalid === 1'b1) && (tready === 1'b0);
         prev_beat  = {tlast, tdata};
      end
   end

   always @(posedge clk) begin
      if (rand_ready) #1 tready = 1'($urandom_range(0, 1));
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned d;
      int unsigned n;
      bit          end_eol;
      logic [7:0]  b;

      rst_n = 1'b0; rx = 1'b1; tready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_frame_err", ferr, 0);
      chk("rst_overflow", ovf, 0);
      rst_n = 1'b1;
      repeat (30) @(posedge clk);

      // 1: byte then EOL
      send_frame(8'h41, 1'b1); mdl_byte(8'h41);
      send_frame(8'h0a, 1'b1); mdl_byte(8'h0a);
      check_stream("t1");

      // 2: lone byte flushed by idle timeout
      send_frame(8'h55, 1'b1); mdl_byte(8'h55);
      wait_beats(1, 400);
      mdl_timeout();
      d = (got_cyc.size() > 0) ? got_cyc[0] - last_stop_cyc : 0;
      // stop sample lands half a bit plus two sync cycles after the stop edge
      chk("t2_timeout_window", (d >= CPB/2 + 2 + TMO*CPB - 2) && (d <= CPB/2 + 2 + TMO*CPB + 2), 1);
      check_stream("t2");

      // 3: framing error, then normal recovery
      send_frame(8'h33, 1'b0); exp_ferr++;
      repeat (3 * CPB) @(posedge clk);
      send_frame(8'h34, 1'b1); mdl_byte(8'h34);
      send_frame(8'h0a, 1'b1); mdl_byte(8'h0a);
      check_stream("t3");

      // 4: stalled sink, overflow drops
      @(posedge clk); #1 tready = 1'b0;
      stall = 1'b1; stall_occ = 0;
      for (int i = 1; i <= 5; i++) begin
         b = 8'(i);
         send_frame(b, 1'b1); mdl_byte(b);
      end
      send_frame(8'h0a, 1'b1); mdl_byte(8'h0a);
      repeat (20) @(posedge clk);
      #1;
      chk("t4_stall_valid", tvalid, 1);
      chk("t4_stall_head", {tlast, tdata}, exp_q[0]);
      chk("t4_overflow_pulses", ovf_cnt, exp_ovf);
      stall = 1'b0;
      tready = 1'b1;
      check_stream("t4");

      // 5: short low glitch while idle
      @(posedge clk); #1 rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (200) @(posedge clk);
      check_stream("t5");

      // randomized packets with random sink backpressure
      for (int p = 0; p < 4; p++) begin
         rand_ready = 1'b1;
         n = $urandom_range(1, 5);
         end_eol = 1'($urandom_range(0, 1));
         for (int j = 0; j < n; j++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1); mdl_byte(b);
         end
         if (end_eol) begin
            send_frame(EOL, 1'b1); mdl_byte(EOL);
         end else begin
            repeat (TMO * CPB + 40) @(posedge clk);
            mdl_timeout();
         end
         rand_ready = 1'b0;
         @(posedge clk); #2 tready = 1'b1;
         check_stream($sformatf("rand%0d", p));
      end

      // 6: reset in the middle of DATA with the line held low
      @(posedge clk); #1 rx = 1'b0;
      repeat (4 * CPB) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_rst_tvalid", tvalid, 0);
      rst_n = 1'b1;
      mdl_pv = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      #1 rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      send_frame(8'h0a, 1'b1); mdl_byte(8'h0a);
      check_stream("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart2axis.md
Name: uart2axis

Overview:
Hardware UART receiver that deserialises an 8N1 serial line into an AXI-Stream byte master. It is the inbound counterpart of the bit-banged emitter path: host bytes arrive on a UART pin and are handed as a packetised stream to a downstream consumer, such as the emitter's stream input or a test sink. Packet boundaries come from an end-of-line character or from line-idle timeout.

Parameters:
clks_per_bit, 868, i_clk cycles per UART bit (100 MHz / 115200); minimum 4
fifo_depth, 4, output FIFO entries, power of two, 2..16
eol_char, 8'h0a, received byte that is emitted with tlast=1
timeout_bits, 20, idle bit-periods after which a pending byte is emitted with tlast=1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous assert, active low
i_uart_rx  in  1  serial input, idles high, asynchronous to i_clk
o_tdata  out  8  received byte
o_tlast  out  1  last byte of packet
o_tvalid  out  1  stream valid
i_tready  in  1  stream ready
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_overflow  out  1  one-cycle pulse: byte dropped because the FIFO was full

Behaviour:
- Reset values: o_tvalid=0, o_tdata=0, o_tlast=0, o_frame_err=0, o_overflow=0. The synchroniser flops reset to 1, the FIFO and pending register are empty, and the FSM enters WAIT_IDLE.
- i_uart_rx passes through a 2-flop synchroniser. All references to "rx" below mean the synchronised value.
- A single bit counter bcnt is reloaded per state. "Expiry" means bcnt==0.
- FSM states and transitions:
  - WAIT_IDLE: move to IDLE when rx==1.
  - IDLE: on rx==0, load bcnt=clks_per_bit/2-1 and move to START.
  - START: on expiry, sample rx. If 0, load bcnt=clks_per_bit-1, clear the bit index, and move to DATA. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: on each expiry, shift rx into the shift register LSB-first and reload bcnt. After the 8th bit, move to STOP.
  - STOP: on expiry, sample rx. If 1, the byte is good; go to IDLE. If 0, pulse o_frame_err, discard the byte, and go to WAIT_IDLE.
- Pending register (1 byte plus valid flag) sits ahead of the FIFO:
  - A good byte equal to eol_char: any valid pending byte is pushed with last=0, then the eol byte is pushed with last=1; pending ends empty. Two pushes in consecutive cycles are allowed.
  - Any other good byte: a valid pending byte is pushed with last=0, and the new byte becomes pending.
  - Idle timeout: while in IDLE with pending valid, count bit periods. After timeout_bits periods, push pending with last=1 and clear it. The count resets when START is entered.
- FIFO: show-ahead, width 9 ({last,data}). o_tvalid = not empty.
  - A pop occurs on o_tvalid && i_tready.
  - A push when full is accepted if a pop happens the same cycle. Otherwise the pushed entry is dropped and o_overflow pulses for 1 cycle.
- Latency: a byte pushed in cycle N is presented on o_tvalid in cycle N+1 when the FIFO was empty.
- AXIS rule: o_tdata and o_tlast stay stable while o_tvalid && !i_tready. o_tvalid never drops without a handshake.
- Reset mid-frame: the partial byte, pending byte and FIFO contents are discarded. After release the FSM waits in WAIT_IDLE, so a line that is still low is not taken as a start bit.
- A new start bit can be detected in the cycle after the STOP sample. Back-to-back frames with no idle time are supported.

Decomposition:
- Shared package uart2axis_pkg holds:
  - the FSM state enum: WAIT_IDLE, IDLE, START, DATA, STOP
  - the width constants for bcnt ($clog2(clks_per_bit)) and the timeout counter
- One sub-module, uart2axis_fifo: synchronous show-ahead FIFO, parameterised width/depth, with i_push/i_pop, o_full/o_empty and asynchronous active-low reset.
- The FSM, synchroniser, pending register and timeout logic live in the top module.

Test Plan:
1. clks_per_bit=8, tready=1, send 0x41 then 0x0a → stream beats {0x41,last=0}, {0x0a,last=1}; no error pulses.
2. Send 0x55 alone, then idle → one beat {0x55,last=1}, issued timeout_bits*8 cycles after the stop sample, ±2 cycles.
3. Frame 0x33 with its stop bit driven 0 → o_frame_err pulses exactly once and no beat is emitted. After rx returns high, 0x34 followed by 0x0a is received normally.
4. tready=0, send 6 back-to-back bytes 0x01..0x05 plus 0x0a (fifo_depth=4):
   - o_overflow pulses once per dropped byte
   - releasing tready yields the first 4 entries in order with stable data during stall
5. 3-cycle low pulse on rx while idle → START glitch rejected, no output, no error.
6. Assert i_rst_n low in the middle of DATA with rx held low, release while still low, then raise rx and send 0x0a → no spurious byte; single beat {0x0a,last=1}.
